// File: rtl/fixed_point_acc_stream.sv
// Kernel-window accumulator: sums NUM_TERMS aligned products, adds bias, saturates to DATA_WIDTH.
// Optional ReLU on the saturated result when FIXED_POINT_ACC_RELU_EN is defined.
module fixed_point_acc_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int INTEGER    = 24,
  parameter int FRACTION   = 8,
  parameter int NUM_TERMS  = 9,
  parameter int GUARD_BITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  prod_valid,
  input  logic [DATA_WIDTH-1:0] prod_data,
  output logic                  prod_ready,
  input  logic [DATA_WIDTH-1:0] bias,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sat,
  input  logic                  out_ready
);

  localparam int ACC_WIDTH = DATA_WIDTH + GUARD_BITS;
  localparam int CNT_W     = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_TERMS - 1);

  if (NUM_TERMS < 1 || NUM_TERMS > 1024 || INTEGER + FRACTION != DATA_WIDTH) begin : g_bad_param
    $error("fixed_point_acc_stream: illegal parameter combination");
  end

  typedef enum logic [1:0] {ACC, FIN, HOLD} state_t;

  state_t state, state_nxt;

  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] bias_ext;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH-1:0] max_v;
  logic signed [ACC_WIDTH-1:0] min_v;
  logic [CNT_W-1:0]            cnt;
  logic                        sat_hi;
  logic                        sat_lo;
  logic [DATA_WIDTH-1:0]       sat_val;
  logic [DATA_WIDTH-1:0]       res;
  logic                        prod_fire;

  assign prod_ext = {{GUARD_BITS{prod_data[DATA_WIDTH-1]}}, prod_data};
  assign bias_ext = {{GUARD_BITS{bias[DATA_WIDTH-1]}}, bias};
  assign sum      = acc + bias_ext;
  assign max_v    = {{(GUARD_BITS+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  assign min_v    = {{(GUARD_BITS+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  assign sat_hi   = sum > max_v;
  assign sat_lo   = sum < min_v;

  always_comb begin
    sat_val = sum[DATA_WIDTH-1:0];
    if (sat_hi) begin
      sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (sat_lo) begin
      sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
  end

`ifdef FIXED_POINT_ACC_RELU_EN
  // out_sat still reflects clipping of the signed sum, not the ReLU clamp.
  assign res = sat_val[DATA_WIDTH-1] ? '0 : sat_val;
`else
  assign res = sat_val;
`endif

  assign prod_fire = prod_valid & prod_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    prod_ready = 1'b0;
    case (state)
      ACC: begin
        prod_ready = 1'b1;
        if (prod_valid && cnt == LAST) begin
          state_nxt = FIN;
        end
      end
      FIN:  state_nxt = HOLD;
      HOLD: begin
        if (out_ready) begin
          state_nxt = ACC;
        end
      end
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (prod_fire) begin
            acc <= acc + prod_ext;
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
          end
        end
        FIN: begin
          out_data  <= res;
          out_sat   <= sat_hi | sat_lo;
          out_valid <= 1'b1;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_acc_stream.sv
// Bench for fixed_point_acc_stream: directed scenarios plus randomized windows against an exact-integer model.
module tb_fixed_point_acc_stream;

  localparam int DW = 32;
  localparam int NT = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          prod_valid;
  logic [DW-1:0] prod_data;
  logic          prod_ready;
  logic [DW-1:0] bias;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_sat;
  logic          out_ready;

  int errors = 0;
  int checks = 0;

  fixed_point_acc_stream #(
    .DATA_WIDTH(DW), .INTEGER(24), .FRACTION(8), .NUM_TERMS(NT), .GUARD_BITS(8)
  ) dut (
    .clk(clk), .reset(reset),
    .prod_valid(prod_valid), .prod_data(prod_data), .prod_ready(prod_ready),
    .bias(bias),
    .out_valid(out_valid), .out_data(out_data), .out_sat(out_sat), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Exact sum of the window plus bias, then clip to the signed output range.
  function automatic void model(input logic [DW-1:0] q[$], input logic [DW-1:0] b,
                                output logic [DW-1:0] d, output logic s);
    longint total = 0;
    foreach (q[i]) total += longint'($signed(q[i]));
    total += longint'($signed(b));
    s = 1'b0;
    if (total > 64'sd2147483647) begin
      d = 32'h7FFF_FFFF; s = 1'b1;
    end else if (total < -64'sd2147483648) begin
      d = 32'h8000_0000; s = 1'b1;
    end else begin
      d = total[DW-1:0];
    end
`ifdef FIXED_POINT_ACC_RELU_EN
    if (d[DW-1]) d = '0;
`endif
  endfunction

  // Present one product and return 1 ns after the edge that accepted it.
  task automatic send(input logic [DW-1:0] v);
    int n = 0;
    prod_valid = 1'b1;
    prod_data  = v;
    while (!prod_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!prod_ready) begin
      errors++;
      $display("FAIL send_timeout: prod_ready=%0b required 1", prod_ready);
    end
    @(posedge clk); #1;
  endtask

  // gap_mode 0: back-to-back, 1: gaps after products 3 and 7, 2: random gaps.
  task automatic send_window(input logic [DW-1:0] p[$], input int gap_mode);
    foreach (p[i]) begin
      send(p[i]);
      if (i < p.size() - 1) begin
        int g = 0;
        if (gap_mode == 1 && (i == 2 || i == 6)) g = 2;
        if (gap_mode == 2) g = $urandom_range(0, 2);
        if (g > 0) begin
          prod_valid = 1'b0;
          repeat (g) begin @(posedge clk); #1; end
        end
      end
    end
    prod_valid = 1'b0;
  endtask

  task automatic wait_result(output logic [DW-1:0] d, output logic s);
    int n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL result_timeout: out_valid=%0b required 1", out_valid);
    end
    d = out_data;
    s = out_sat;
  endtask

  task automatic ack(input int delay);
    repeat (delay) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || prod_ready !== 1'b1) begin
      errors++;
      $display("FAIL ack_release: out_valid=%0b prod_ready=%0b required 0/1", out_valid, prod_ready);
    end
  endtask

  task automatic run_window(input string name, input logic [DW-1:0] p[$], input logic [DW-1:0] b,
                            input int gap_mode, input int delay);
    logic [DW-1:0] d, ed;
    logic          s, es;
    bias = b;
    send_window(p, gap_mode);
    wait_result(d, s);
    model(p, b, ed, es);
    checks++;
    if (d !== ed || s !== es) begin
      errors++;
      $display("FAIL %s: out_data=%h out_sat=%0b required %h/%0b", name, d, s, ed, es);
    end
    ack(delay);
  endtask

  function automatic void fill(ref logic [DW-1:0] q[$], input logic [DW-1:0] v);
    q = {};
    for (int i = 0; i < NT; i++) q.push_back(v);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_sat !== 1'b0 || prod_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid=%0b data=%h sat=%0b ready=%0b required 0/0/0/1",
               out_valid, out_data, out_sat, prod_ready);
    end
  endtask

  task automatic test_basic();
    logic [DW-1:0] q[$];
    fill(q, 32'h0000_0100);
    bias = 32'h0000_0080;
    send_window(q, 0);
    // Edge of the 9th transfer just passed: FIN cycle, result registers on the next edge.
    checks++;
    if (out_valid !== 1'b0 || prod_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_fin_cycle: out_valid=%0b prod_ready=%0b required 0/0", out_valid, prod_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h0000_0980 || out_sat !== 1'b0) begin
      errors++;
      $display("FAIL basic_sum: valid=%0b data=%h sat=%0b required 1/00000980/0", out_valid, out_data, out_sat);
    end
    ack(0);
  endtask

  task automatic test_saturation();
    logic [DW-1:0] q[$];
    fill(q, 32'h7FFF_FFFF);
    run_window("pos_sat", q, 32'h0000_0100, 0, 1);
    fill(q, 32'h0000_0100);
    run_window("after_sat_clear", q, 32'h0, 0, 0);
    fill(q, 32'h8000_0000);
    run_window("neg_sat", q, 32'hFFFF_FF00, 0, 0);
  endtask

  task automatic test_negative();
    logic [DW-1:0] q[$];
    logic [DW-1:0] d, ed;
    logic          s;
    fill(q, 32'hFFFF_FF00);
    bias = 32'h0;
    send_window(q, 0);
    wait_result(d, s);
`ifdef FIXED_POINT_ACC_RELU_EN
    ed = 32'h0000_0000;
`else
    ed = 32'hFFFF_F700;
`endif
    checks++;
    if (d !== ed || s !== 1'b0) begin
      errors++;
      $display("FAIL negative: out_data=%h out_sat=%0b required %h/0", d, s, ed);
    end
    ack(0);
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] q[$];
    logic [DW-1:0] held;
    fill(q, 32'h0000_0100);
    bias = 32'h0;
    send_window(q, 0);
    @(posedge clk); #1;
    held = out_data;
    checks++;
    if (held !== 32'h0000_0900) begin
      errors++;
      $display("FAIL bp_first: out_data=%h required 00000900", held);
    end
    prod_valid = 1'b1;
    prod_data  = 32'h0001_0000;
    repeat (5) begin
      checks++;
      if (prod_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held) begin
        errors++;
        $display("FAIL bp_hold: ready=%0b valid=%0b data=%h required 0/1/%h", prod_ready, out_valid, out_data, held);
      end
      @(posedge clk); #1;
    end
    prod_valid = 1'b0;
    ack(0);
    run_window("bp_next", q, 32'h0, 0, 0);
  endtask

  task automatic test_bubbles();
    logic [DW-1:0] q[$];
    fill(q, 32'h0000_0100);
    run_window("bubbles", q, 32'h0000_0080, 1, 0);
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] q[$];
    for (int i = 0; i < 4; i++) send(32'h0000_0100);
    prod_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    fill(q, 32'h0000_0200);
    run_window("reset_mid", q, 32'h0, 0, 0);
    // Reset while a result is pending drops it.
    send_window(q, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || prod_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold: valid=%0b data=%h ready=%0b required 0/0/1", out_valid, out_data, prod_ready);
    end
    fill(q, 32'h0000_0300);
    run_window("after_reset_hold", q, 32'h0, 0, 0);
  endtask

  task automatic test_random();
    logic [DW-1:0] q[$];
    logic [DW-1:0] b;
    for (int w = 0; w < 24; w++) begin
      int mode = $urandom_range(0, 2);
      q = {};
      for (int i = 0; i < NT; i++) begin
        int t;
        logic [DW-1:0] v;
        if (mode == 0) begin
          t = int'($urandom_range(0, 2047)) - 1024;
          v = t;
        end else if (mode == 1) begin
          v = $urandom;
        end else begin
          v = ($urandom_range(0, 1) != 0) ? 32'h7FFF_0000 + $urandom_range(0, 65535)
                                           : 32'h8000_0000 + $urandom_range(0, 65535);
        end
        q.push_back(v);
      end
      b = ($urandom_range(0, 1) != 0) ? $urandom : 32'h0000_0040;
      run_window($sformatf("random_%0d", w), q, b, 2, $urandom_range(0, 3));
    end
  endtask

  initial begin
    reset      = 1'b1;
    prod_valid = 1'b0;
    prod_data  = '0;
    bias       = '0;
    out_ready  = 1'b0;
    test_reset();
    test_basic();
    test_saturation();
    test_negative();
    test_backpressure();
    test_bubbles();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
